rename_dispatch_ss: RTL and testbench

Parametrised SS-wide rename/dispatch stage, successor to the fixed 2-wide version. It does the following in one cycle:
- accepts up to SS in-order instructions from the instruction queue;
- renames sources through the RAT, with intra-group bypass and same-cycle CDB wakeup;
- allocates destinations from the free list and ROB ids from the ROB tail.

The renamed group is registered into a one-cycle output stage feeding the reservation station. Partial dispatch is supported: the group is cut at the first slot lacking ROB, RS or free-list capacity.

---
 rtl/rename_dispatch_ss.sv | 145 ++++++++++++++
 tb/tb_rename_dispatch_ss.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rename_dispatch_ss.sv
// rename_dispatch_ss: SS-wide rename/dispatch with intra-group bypass, CDB wakeup and partial dispatch.
// The renamed group is registered into a single output stage that feeds the reservation station.
module rename_dispatch_ss #(
   parameter int SS         = 2,
   parameter int PR_ENTRIES = 64,
   parameter int ROB_DEPTH  = 8,
   parameter int NCDB       = 1,
   localparam int PRW = $clog2(PR_ENTRIES),
   localparam int RBW = $clog2(ROB_DEPTH),
   localparam int CW  = $clog2(SS + 1),
   localparam int FCW = $clog2(PR_ENTRIES + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [SS-1:0]                 in_valid,
   input  logic [SS-1:0][4:0]            in_rs1,
   input  logic [SS-1:0][4:0]            in_rs2,
   input  logic [SS-1:0][4:0]            in_rd,
   input  logic [SS-1:0]                 in_rs1_needed,
   input  logic [SS-1:0]                 in_rs2_needed,
   input  logic [SS-1:0]                 in_rd_we,
   output logic [CW-1:0]                 pop_count,
   input  logic [SS-1:0][PRW-1:0]        rat_rs1,
   input  logic [SS-1:0][PRW-1:0]        rat_rs2,
   input  logic [SS-1:0]                 rat_rs1_rdy,
   input  logic [SS-1:0]                 rat_rs2_rdy,
   output logic [SS-1:0]                 rat_we,
   output logic [SS-1:0][4:0]            rat_wr_arch,
   output logic [SS-1:0][PRW-1:0]        rat_wr_preg,
   input  logic [SS-1:0][PRW-1:0]        free_preg,
   input  logic [FCW-1:0]                free_count,
   output logic [CW-1:0]                 free_pop,
   input  logic [RBW-1:0]                rob_tail,
   input  logic [RBW:0]                  rob_space,
   input  logic [CW-1:0]                 rs_space,
   input  logic [NCDB-1:0]               cdb_valid,
   input  logic [NCDB-1:0][PRW-1:0]      cdb_preg,
   output logic [SS-1:0]                 out_valid,
   output logic [SS-1:0][PRW-1:0]        out_prs1,
   output logic [SS-1:0][PRW-1:0]        out_prs2,
   output logic [SS-1:0][PRW-1:0]        out_prd,
   output logic [SS-1:0][RBW-1:0]        out_rob_id,
   output logic [SS-1:0]                 out_src1_rdy,
   output logic [SS-1:0]                 out_src2_rdy
);
   int                        w_n;
   int                        w_free;
   logic [SS-1:0]             w_alloc;
   logic [SS-1:0][PRW-1:0]    w_newp;
   logic [SS-1:0][PRW-1:0]    w_prs1, w_prs2, w_prd;
   logic [SS-1:0][RBW-1:0]    w_rob;
   logic [SS-1:0]             w_rdy1, w_rdy2;
   logic [SS-1:0]             r_valid, r_rdy1, r_rdy2;
   logic [SS-1:0][PRW-1:0]    r_prs1, r_prs2, r_prd;
   logic [SS-1:0][RBW-1:0]    r_rob;

   // Returns {ready, preg}: zero/unused source, then youngest earlier in-group writer, then RAT with CDB wakeup.
   function automatic logic [PRW:0] resolve(int j, logic [4:0] r, logic nd, logic [PRW-1:0] rp, logic rr,
                                            logic [SS-1:0] al, logic [SS-1:0][4:0] rd,
                                            logic [SS-1:0][PRW-1:0] np);
      logic [PRW:0] res;
      res = {rr, rp};
      for (int c = 0; c < NCDB; c++)
         if (cdb_valid[c] && cdb_preg[c] == rp) res[PRW] = 1'b1;
      for (int i = 0; i < SS; i++)
         if (i < j && al[i] && rd[i] == r) res = {1'b0, np[i]};
      if (!nd || r == 5'd0) res = {1'b1, {PRW{1'b0}}};
      return res;
   endfunction

   // Capacity limits are all monotone in k, so the group is the longest prefix that still fits.
   always_comb begin
      int   a;
      logic go;
      a      = 0;
      go     = ~(rst | flush);
      w_n    = 0;
      w_free = 0;
      for (int j = 0; j < SS; j++) begin
         w_alloc[j] = in_valid[j] & in_rd_we[j] & (in_rd[j] != 5'd0);
         w_newp[j]  = '0;
         for (int k = 0; k < SS; k++)
            if (k == a) w_newp[j] = free_preg[k];
         go = go & in_valid[j] & (j + 1 <= int'(rob_space)) & (j + 1 <= int'(rs_space))
                 & (a + int'(w_alloc[j]) <= int'(free_count));
         if (go) begin
            w_n    = j + 1;
            w_free = w_free + int'(w_alloc[j]);
         end
         a = a + int'(w_alloc[j]);
      end
   end

   always_comb begin
      for (int j = 0; j < SS; j++) begin
         {w_rdy1[j], w_prs1[j]} = resolve(j, in_rs1[j], in_rs1_needed[j], rat_rs1[j], rat_rs1_rdy[j],
                                          w_alloc, in_rd, w_newp);
         {w_rdy2[j], w_prs2[j]} = resolve(j, in_rs2[j], in_rs2_needed[j], rat_rs2[j], rat_rs2_rdy[j],
                                          w_alloc, in_rd, w_newp);
         rat_we[j] = w_alloc[j] && j < w_n;
         for (int k = 0; k < SS; k++)
            if (k > j && k < w_n && w_alloc[k] && in_rd[k] == in_rd[j]) rat_we[j] = 1'b0;
         rat_wr_arch[j] = in_rd[j];
         rat_wr_preg[j] = w_newp[j];
         w_prd[j]       = w_alloc[j] ? w_newp[j] : '0;
         w_rob[j]       = rob_tail + RBW'(j);
      end
   end

   assign pop_count = CW'(w_n);
   assign free_pop  = CW'(w_free);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_prs1  <= '0;
         r_prs2  <= '0;
         r_prd   <= '0;
         r_rob   <= '0;
         r_rdy1  <= '0;
         r_rdy2  <= '0;
      end else begin
         for (int j = 0; j < SS; j++) begin
            r_valid[j] <= j < w_n;
            if (j < w_n) begin
               r_prs1[j] <= w_prs1[j];
               r_prs2[j] <= w_prs2[j];
               r_prd[j]  <= w_prd[j];
               r_rob[j]  <= w_rob[j];
               r_rdy1[j] <= w_rdy1[j];
               r_rdy2[j] <= w_rdy2[j];
            end
         end
      end
   end

   assign out_valid    = r_valid;
   assign out_prs1     = r_prs1;
   assign out_prs2     = r_prs2;
   assign out_prd      = r_prd;
   assign out_rob_id   = r_rob;
   assign out_src1_rdy = r_rdy1;
   assign out_src2_rdy = r_rdy2;
endmodule

// File: tb/tb_rename_dispatch_ss.sv
// tb_rename_dispatch_ss: directed vectors with hand-computed expectations for the 2-wide configuration.
module tb_rename_dispatch_ss;
   localparam int SS = 2, PRW = 6, RBW = 3;
   logic                    clk, rst, flush;
   logic [SS-1:0]           in_valid, in_rs1_needed, in_rs2_needed, in_rd_we;
   logic [SS-1:0][4:0]      in_rs1, in_rs2, in_rd;
   logic [1:0]              pop_count, free_pop, rs_space;
   logic [SS-1:0][PRW-1:0]  rat_rs1, rat_rs2, rat_wr_preg, free_preg;
   logic [SS-1:0]           rat_rs1_rdy, rat_rs2_rdy, rat_we;
   logic [SS-1:0][4:0]      rat_wr_arch;
   logic [6:0]              free_count;
   logic [RBW-1:0]          rob_tail;
   logic [RBW:0]            rob_space;
   logic [0:0]              cdb_valid;
   logic [0:0][PRW-1:0]     cdb_preg;
   logic [SS-1:0]           out_valid, out_src1_rdy, out_src2_rdy;
   logic [SS-1:0][PRW-1:0]  out_prs1, out_prs2, out_prd;
   logic [SS-1:0][RBW-1:0]  out_rob_id;
   int checks = 0, failures = 0;

   rename_dispatch_ss dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rd(in_rd), .in_rs1_needed(in_rs1_needed), .in_rs2_needed(in_rs2_needed), .in_rd_we(in_rd_we),
      .pop_count(pop_count), .rat_rs1(rat_rs1), .rat_rs2(rat_rs2), .rat_rs1_rdy(rat_rs1_rdy),
      .rat_rs2_rdy(rat_rs2_rdy), .rat_we(rat_we), .rat_wr_arch(rat_wr_arch), .rat_wr_preg(rat_wr_preg),
      .free_preg(free_preg), .free_count(free_count), .free_pop(free_pop), .rob_tail(rob_tail),
      .rob_space(rob_space), .rs_space(rs_space), .cdb_valid(cdb_valid), .cdb_preg(cdb_preg),
      .out_valid(out_valid), .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
      .out_rob_id(out_rob_id), .out_src1_rdy(out_src1_rdy), .out_src2_rdy(out_src2_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      flush = 0; in_valid = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
      in_rs1_needed = '0; in_rs2_needed = '0; in_rd_we = '0;
      rat_rs1 = '0; rat_rs2 = '0; rat_rs1_rdy = '0; rat_rs2_rdy = '0;
      free_preg = '0; free_count = 7'd64; rob_tail = '0; rob_space = 4'd8; rs_space = 2'd2;
      cdb_valid = '0; cdb_preg = '0;
   endtask

   task automatic two_alu(input logic [4:0] d0, input logic [4:0] d1, input logic [5:0] p0, input logic [5:0] p1);
      idle();
      in_valid = 2'b11; in_rd_we = 2'b11; in_rd[0] = d0; in_rd[1] = d1;
      free_preg[0] = p0; free_preg[1] = p1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      rst = 1;
      two_alu(5'd1, 5'd2, 6'd10, 6'd11);
      #2;
      chk("rst_pop", pop_count, 0);
      chk("rst_free_pop", free_pop, 0);
      chk("rst_rat_we", rat_we, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_prd", out_prd, 0);
      tick();
      rst = 0;
      idle();
      tick();
      // independent pair, rob_tail=3
      two_alu(5'd1, 5'd2, 6'd10, 6'd11);
      rob_tail = 3'd3;
      #1;
      chk("t1_pop", pop_count, 2);
      chk("t1_free_pop", free_pop, 2);
      chk("t1_rat_we", rat_we, 2'b11);
      tick();
      chk("t1_out_valid", out_valid, 2'b11);
      chk("t1_rob0", out_rob_id[0], 3);
      chk("t1_rob1", out_rob_id[1], 4);
      chk("t1_prd0", out_prd[0], 10);
      chk("t1_prd1", out_prd[1], 11);
      idle();
      tick();
      chk("t1_one_cycle", out_valid, 0);
      // intra-group bypass x5
      two_alu(5'd5, 5'd6, 6'd20, 6'd21);
      in_rs1[1] = 5'd5; in_rs1_needed[1] = 1; rat_rs1[1] = 6'd40; rat_rs1_rdy[1] = 1;
      #1;
      chk("t2_rat_we", rat_we, 2'b11);
      chk("t2_wr_arch0", rat_wr_arch[0], 5);
      chk("t2_wr_preg0", rat_wr_preg[0], 20);
      tick();
      chk("t2_prs1_1", out_prs1[1], 20);
      chk("t2_rdy1_1", out_src1_rdy[1], 0);
      chk("t2_prd1", out_prd[1], 21);
      // both write x7
      two_alu(5'd7, 5'd7, 6'd30, 6'd31);
      #1;
      chk("t3_rat_we", rat_we, 2'b10);
      chk("t3_wr_preg1", rat_wr_preg[1], 31);
      chk("t3_free_pop", free_pop, 2);
      tick();
      // ROB wrap
      two_alu(5'd1, 5'd2, 6'd3, 6'd4);
      rob_tail = 3'd7; rob_space = 4'd2;
      tick();
      chk("t4_rob0", out_rob_id[0], 7);
      chk("t4_rob1", out_rob_id[1], 0);
      rob_space = 4'd1;
      #1;
      chk("t4_pop_rob1", pop_count, 1);
      tick();
      chk("t4_out_valid", out_valid, 2'b01);
      // no free regs: x0 dest passes, x3 dest blocks
      two_alu(5'd0, 5'd3, 6'd50, 6'd51);
      free_count = 7'd0;
      in_rs1[0] = 5'd0; in_rs1_needed[0] = 1; rat_rs1[0] = 6'd9;
      #1;
      chk("t5_pop", pop_count, 1);
      chk("t5_free_pop", free_pop, 0);
      tick();
      chk("t5_out_valid", out_valid, 2'b01);
      chk("t5_prd0", out_prd[0], 0);
      chk("t5_prs1_0", out_prs1[0], 0);
      chk("t5_rdy1_0", out_src1_rdy[0], 1);
      // CDB wakeup on RAT preg 12; preg 13 stays not-ready
      idle();
      in_valid = 2'b01; in_rs1[0] = 5'd4; in_rs2[0] = 5'd6; in_rs1_needed[0] = 1; in_rs2_needed[0] = 1;
      rat_rs1[0] = 6'd12; rat_rs2[0] = 6'd13; cdb_valid = 1'b1; cdb_preg[0] = 6'd12;
      #1;
      chk("t6_pop", pop_count, 1);
      chk("t6_rat_we", rat_we, 0);
      tick();
      chk("t6_prs1", out_prs1[0], 12);
      chk("t6_rdy1", out_src1_rdy[0], 1);
      chk("t6_rdy2", out_src2_rdy[0], 0);
      // flush
      two_alu(5'd1, 5'd2, 6'd10, 6'd11);
      flush = 1;
      #1;
      chk("t7_pop", pop_count, 0);
      chk("t7_rat_we", rat_we, 0);
      chk("t7_free_pop", free_pop, 0);
      tick();
      chk("t7_out_valid", out_valid, 0);
      // non-contiguous valid, then RS limit
      two_alu(5'd1, 5'd2, 6'd10, 6'd11);
      in_valid = 2'b10;
      #1;
      chk("t8_gap_pop", pop_count, 0);
      in_valid = 2'b11; rs_space = 2'd1;
      #1;
      chk("t8_rs_pop", pop_count, 1);
      chk("t8_rs_rat_we", rat_we, 2'b01);
      rs_space = 2'd0;
      #1;
      chk("t8_rs0_pop", pop_count, 0);
      rs_space = 2'd2;
      tick();
      chk("t8_out_valid", out_valid, 2'b11);
      // async reset mid-cycle
      #2 rst = 1;
      #1;
      chk("t9_async_valid", out_valid, 0);
      chk("t9_async_prd", out_prd, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
